// File: rtl/dice_roll_ctrl_if.sv
// dice_roll_ctrl_if: player request / die counter / display bundle for the roll sequencer
interface dice_roll_ctrl_if #(parameter int SCORE_W = 8);
  logic [1:0] req;
  logic clr_scores;
  logic [2:0] die_val;
  logic cnt_up;
  logic busy;
  logic active_player;
  logic [1:0] ack;
  logic [2:0] result;
  logic [6:0] seg7;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  modport master(output req, clr_scores, die_val,
                 input cnt_up, busy, active_player, ack, result, seg7, score0, score1);
  modport slave(input req, clr_scores, die_val,
                output cnt_up, busy, active_player, ack, result, seg7, score0, score1);
endinterface

// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: round-robin two-player roll sequencer driving die counter, seg7 and score accumulators
module dice_roll_ctrl #(
  parameter int ROLL_CYCLES = 16,
  parameter int HOLD_CYCLES = 32,
  parameter int SCORE_W = 8
) (
  input logic clock,
  input logic reset,
  dice_roll_ctrl_if.slave bus
);
  localparam int TW = $clog2((ROLL_CYCLES > HOLD_CYCLES ? ROLL_CYCLES : HOLD_CYCLES) + 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, ROLL, LATCH, SHOW} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic last_grant, last_n, player_n;
  logic [1:0] ack_n;
  logic [2:0] lv, result_n;
  logic [SCORE_W-1:0] cur, sat, score0_n, score1_n;
  logic [SCORE_W:0] sum;
  logic [6:0] seg7_n;
  function automatic logic [6:0] enc(input logic [2:0] v);
    return v == 3'd1 ? 7'b1111001 :
           v == 3'd2 ? 7'b0100100 :
           v == 3'd3 ? 7'b0110000 :
           v == 3'd4 ? 7'b0011001 :
           v == 3'd5 ? 7'b0010010 :
           v == 3'd6 ? 7'b0000010 : BLANK;
  endfunction
  always_comb begin
    lv = (bus.die_val == 3'd0 || bus.die_val == 3'd7) ? 3'd1 : bus.die_val;
    cur = bus.active_player ? bus.score1 : bus.score0;
    sum = {1'b0, cur} + (SCORE_W+1)'(lv);
    sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    state_n = state;
    timer_n = timer;
    last_n = last_grant;
    player_n = bus.active_player;
    ack_n = 2'b00;
    result_n = bus.result;
    score0_n = bus.score0;
    score1_n = bus.score1;
    case (state)
      IDLE:
        if (bus.clr_scores) begin
          score0_n = '0;
          score1_n = '0;
        end else if (|bus.req) begin
          player_n = &bus.req ? ~last_grant : bus.req[1];
          last_n = player_n;
          timer_n = TW'(ROLL_CYCLES - 1);
          state_n = ROLL;
        end
      ROLL:
        if (!bus.req[bus.active_player]) state_n = IDLE;
        else if (timer == '0) state_n = LATCH;
        else timer_n = timer - TW'(1);
      LATCH: begin
        result_n = lv;
        score0_n = bus.active_player ? bus.score0 : sat;
        score1_n = bus.active_player ? sat : bus.score1;
        ack_n = bus.active_player ? 2'b10 : 2'b01;
        timer_n = TW'(HOLD_CYCLES - 1);
        state_n = SHOW;
      end
      default:
        if (timer == '0) state_n = IDLE;
        else timer_n = timer - TW'(1);
    endcase
    seg7_n = state_n == SHOW ? enc(result_n) : state_n == IDLE ? BLANK : enc(bus.die_val);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      last_grant <= 1'b1;
      bus.active_player <= 1'b0;
      bus.ack <= 2'b00;
      bus.result <= 3'b000;
      bus.score0 <= '0;
      bus.score1 <= '0;
      bus.seg7 <= BLANK;
      bus.busy <= 1'b0;
      bus.cnt_up <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      last_grant <= last_n;
      bus.active_player <= player_n;
      bus.ack <= ack_n;
      bus.result <= result_n;
      bus.score0 <= score0_n;
      bus.score1 <= score1_n;
      bus.seg7 <= seg7_n;
      bus.busy <= state_n != IDLE;
      bus.cnt_up <= state_n == ROLL;
    end
endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb_dice_roll_ctrl: directed and randomized rolls checked against a per-roll score/arbitration model
module tb_dice_roll_ctrl;
  localparam int RC = 4;
  localparam int HC = 3;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  dice_roll_ctrl_if #(.SCORE_W(SW)) bus();
  dice_roll_ctrl #(.ROLL_CYCLES(RC), .HOLD_CYCLES(HC), .SCORE_W(SW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  int nvec = 0;
  int nerr = 0;
  int ms0 = 0;
  int ms1 = 0;
  int last = 1;
  logic [6:0] segtab [8];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic roll(input logic [1:0] r, input int abort_at, input int die);
    int w;
    int v;
    logic [2:0] prev;
    logic [2:0] lat;
    w = (r == 2'b11) ? 1 - last : int'(r[1]);
    last = w;
    v = 0;
    lat = 3'd0;
    bus.req = r;
    bus.die_val = die < 0 ? 3'($urandom_range(0, 7)) : 3'(die);
    prev = bus.die_val;
    for (int c = 1; c <= RC + HC + 2; c++) begin
      @(negedge clock);
      if (abort_at != 0 && c == abort_at + 1) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_cnt_up", bus.cnt_up, 0);
        chk("abort_ack", bus.ack, 0);
        chk("abort_seg7", bus.seg7, 7'h7f);
        chk("abort_score0", bus.score0, ms0);
        chk("abort_score1", bus.score1, ms1);
        return;
      end
      chk("busy", bus.busy, c <= RC + HC + 1);
      chk("cnt_up", bus.cnt_up, c <= RC);
      chk("ack", bus.ack, c == RC + 2 ? (w == 1 ? 2 : 1) : 0);
      if (c == 1) chk("player", bus.active_player, w);
      if (c <= RC) chk("seg7_tumble", bus.seg7, segtab[prev]);
      if (c == RC + 2) begin
        v = (lat == 3'd0 || lat == 3'd7) ? 1 : int'(lat);
        if (w == 1) ms1 = ms1 + v > SMAX ? SMAX : ms1 + v;
        else ms0 = ms0 + v > SMAX ? SMAX : ms0 + v;
        chk("result", bus.result, v);
        chk("score0", bus.score0, ms0);
        chk("score1", bus.score1, ms1);
        chk("player_show", bus.active_player, w);
        bus.req[w] = 1'b0;
      end
      if (c >= RC + 2) chk("seg7_show", bus.seg7, c <= RC + HC + 1 ? segtab[v] : 7'h7f);
      if (abort_at == c) bus.req = 2'b00;
      bus.die_val = die < 0 ? 3'($urandom_range(0, 7)) : 3'(die);
      prev = bus.die_val;
      if (c == RC + 1) lat = bus.die_val;
    end
  endtask
  task automatic clr();
    bus.clr_scores = 1'b1;
    bus.req = 2'b01;
    @(negedge clock);
    ms0 = 0;
    ms1 = 0;
    chk("clr_score0", bus.score0, 0);
    chk("clr_score1", bus.score1, 0);
    chk("clr_busy", bus.busy, 0);
    bus.clr_scores = 1'b0;
    bus.req = 2'b00;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [1:0] r;
    segtab = '{7'h7f, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'h7f};
    bus.req = 2'b00;
    bus.clr_scores = 1'b0;
    bus.die_val = 3'd1;
    repeat (2) @(negedge clock);
    chk("rst_seg7", bus.seg7, 7'h7f);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_scores", {bus.score1, bus.score0}, 0);
    chk("rst_cnt_up", bus.cnt_up, 0);
    chk("rst_player", bus.active_player, 0);
    reset = 1'b0;
    roll(2'b01, 0, 3);
    chk("seg7_three", segtab[3], 7'b0110000);
    roll(2'b11, 0, -1);
    roll(bus.req, 0, -1);
    roll(2'b01, 0, 7);
    roll(2'b01, 2, -1);
    roll(2'b10, 1, 5);
    for (int i = 0; i < 12; i++) begin
      r = bus.req != 2'b00 ? bus.req : 2'($urandom_range(1, 3));
      roll(r, (r != 2'b11 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, RC)) : 0, -1);
    end
    if (bus.req != 2'b00) roll(bus.req, 0, -1);
    clr();
    roll(2'b10, 0, 6);
    roll(2'b10, 0, 6);
    roll(2'b10, 0, 2);
    chk("score1_14", bus.score1, 14);
    roll(2'b10, 0, 6);
    chk("score1_sat", bus.score1, SMAX);
    clr();
    roll(2'b01, 0, 5);
    chk("score0_5", bus.score0, 5);
    bus.req = 2'b01;
    repeat (RC + 3) @(negedge clock);
    chk("mid_show_busy", bus.busy, 1);
    #1 reset = 1'b1;
    #1;
    ms0 = 0;
    ms1 = 0;
    last = 1;
    chk("arst_seg7", bus.seg7, 7'h7f);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ack", bus.ack, 0);
    chk("arst_score0", bus.score0, ms0);
    chk("arst_result", bus.result, 0);
    chk("arst_cnt_up", bus.cnt_up, 0);
    bus.req = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_idle", bus.busy, 0);
    roll(2'b11, 0, -1);
    roll(bus.req, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
